// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide engine for the EX stage: shift-add multiply,
// restoring divide, sign fix-up, then a one-cycle done pulse carrying {HI, LO}.
module mult_div_unit #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  funct,
    input  logic        start,
    input  logic [31:0] operand_1,
    input  logic [31:0] operand_2,
    input  logic        flush,
    output logic        busy,
    output logic        stall_request,
    output logic        mult_div_done,
    output logic [63:0] mult_div_result
);

    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam int         CNT_W       = $clog2(ITER);

    // IDLE wait for start | CALC iterate | FIX sign fix / result write | DONE pulse
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               sgn_q, sgn_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [31:0]        opb_q, opb_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [63:0]        result_q, result_d;

    logic               op_mul, op_div, op_signed, accept, div_zero;
    logic               s1, s2;
    logic [31:0]        mag1, mag2;
    logic [32:0]        mul_sum;
    logic [31:0]        rem_sub;
    logic               no_borrow;
    logic [63:0]        prod_fix;
    logic [31:0]        hi_fix, lo_fix;

    assign op_mul    = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
    assign op_div    = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    assign op_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    assign s1        = op_signed & operand_1[31];
    assign s2        = op_signed & operand_2[31];
    assign mag1      = s1 ? -operand_1 : operand_1;
    assign mag2      = s2 ? -operand_2 : operand_2;
    assign div_zero  = op_div && (operand_2 == 32'd0);
    assign accept    = (state_q == S_IDLE) && start && (op_mul || op_div) && !flush;

    // Multiply: {hi, lo} shifts right; lo starts as the multiplier.
    assign mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opb_q : 32'd0)};
    // Divide: lo shifts the dividend out as quotient bits shift in; hi is the remainder.
    assign no_borrow = {hi_q, lo_q[31]} >= {1'b0, opb_q};
    assign rem_sub   = {hi_q[30:0], lo_q[31]} - opb_q;

    assign prod_fix  = (sgn_q && neg_res_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
    assign hi_fix    = (sgn_q && neg_rem_q) ? -hi_q : hi_q;
    assign lo_fix    = (sgn_q && neg_res_q) ? -lo_q : lo_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        sgn_d     = sgn_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        result_d  = result_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d    = '0;
                    is_div_d = op_div;
                    if (div_zero) begin
                        // Sign flags cleared so FIX passes the raw dividend through.
                        state_d   = S_FIX;
                        sgn_d     = 1'b0;
                        neg_res_d = 1'b0;
                        neg_rem_d = 1'b0;
                        hi_d      = operand_1;
                        lo_d      = 32'hFFFF_FFFF;
                    end else begin
                        state_d   = S_CALC;
                        sgn_d     = op_signed;
                        neg_res_d = s1 ^ s2;
                        neg_rem_d = s1;
                        hi_d      = 32'd0;
                        lo_d      = op_div ? mag1 : mag2;
                        opb_d     = op_div ? mag2 : mag1;
                    end
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (is_div_q) begin
                        hi_d = no_borrow ? rem_sub : {hi_q[30:0], lo_q[31]};
                        lo_d = {lo_q[30:0], no_borrow};
                    end else begin
                        hi_d = mul_sum[32:1];
                        lo_d = {mul_sum[0], lo_q[31:1]};
                    end
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_DONE;
                    result_d = is_div_q ? {hi_fix, lo_fix} : prod_fix;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            sgn_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opb_q     <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            result_q  <= 64'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            sgn_q     <= sgn_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            result_q  <= result_d;
        end
    end

    assign busy            = (state_q != S_IDLE);
    assign stall_request   = busy || accept;
    assign mult_div_done   = (state_q == S_DONE);
    assign mult_div_result = result_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_mult_div_unit;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  funct;
    logic        start;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        flush;
    logic        busy;
    logic        stall_request;
    logic        mult_div_done;
    logic [63:0] mult_div_result;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.ITER(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .funct          (funct),
        .start          (start),
        .operand_1      (operand_1),
        .operand_2      (operand_2),
        .flush          (flush),
        .busy           (busy),
        .stall_request  (stall_request),
        .mult_div_done  (mult_div_done),
        .mult_div_result(mult_div_result)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] ref_result(input logic [5:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, q, r, p;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            F_MULTU: return ua * ub;
            F_MULT: begin
                p = sa * sb;
                return p;
            end
            F_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            F_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: return 64'd0;
        endcase
    endfunction

    // From the current sampling point, wait up to maxc cycles for done; returns
    // the cycle offset at which done was seen (0 = never) and counts busy-low cycles.
    task automatic wait_done(input int first_k, input int maxc, output int lat, output int busy_bad);
        lat      = 0;
        busy_bad = 0;
        for (int k = first_k; k <= maxc; k++) begin
            if (!busy) busy_bad++;
            if (mult_div_done) begin
                lat = k;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        logic [63:0] exp;
        int          lat, busy_bad, exp_lat;
        exp     = ref_result(f, a, b);
        exp_lat = ((f == F_DIV || f == F_DIVU) && b == 32'd0) ? 2 : 34;
        @(negedge clk);
        funct = f; operand_1 = a; operand_2 = b; start = 1'b1;
        #1;
        check_val({tag, ".stall_acc"}, 64'(stall_request), 64'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(1, 60, lat, busy_bad);
        check_val({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check_val({tag, ".busy"}, 64'(busy_bad), 64'd0);
        check_val({tag, ".result"}, mult_div_result, exp);
        @(posedge clk);
        #1;
        check_val({tag, ".pulse_end"}, {62'd0, mult_div_done, busy}, 64'd0);
        check_val({tag, ".hold"}, mult_div_result, exp);
    endtask

    initial begin
        logic [63:0] prev, exp;
        logic [5:0]  fsel [4];
        logic [5:0]  f;
        logic [31:0] a, b;
        int          lat, busy_bad, seen;

        fsel[0] = F_MULT; fsel[1] = F_MULTU; fsel[2] = F_DIV; fsel[3] = F_DIVU;
        rst = 1'b1; funct = F_MFHI; start = 1'b0; flush = 1'b0;
        operand_1 = 32'd0; operand_2 = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_outputs", {61'd0, busy, stall_request, mult_div_done}, 64'd0);
        check_val("reset_result", mult_div_result, 64'd0);
        rst = 1'b0;

        run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        check_val("multu_max_const", mult_div_result, 64'hFFFF_FFFE_0000_0001);
        run_op(F_MULT, 32'hFFFF_FFFD, 32'd7, "mult_neg");
        check_val("mult_neg_const", mult_div_result, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(F_MULT, 32'h8000_0000, 32'h8000_0000, "mult_min");
        check_val("mult_min_const", mult_div_result, 64'h4000_0000_0000_0000);
        run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg");
        check_val("div_neg_const", mult_div_result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op(F_DIVU, 32'd100, 32'd7, "divu");
        check_val("divu_const", mult_div_result, {32'd2, 32'd14});
        run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        check_val("div_ovf_const", mult_div_result, {32'd0, 32'h8000_0000});
        run_op(F_DIVU, 32'd100, 32'd0, "divu_zero");
        check_val("divu_zero_const", mult_div_result, {32'd100, 32'hFFFF_FFFF});
        run_op(F_DIV, 32'hFFFF_FF00, 32'd0, "div_zero");

        // flush mid-CALC
        prev = mult_div_result;
        @(negedge clk);
        funct = F_MULTU; operand_1 = 32'd5; operand_2 = 32'd6; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_val("flush_busy", 64'(busy), 64'd0);
        seen = 0;
        repeat (40) begin
            if (mult_div_done) seen++;
            @(posedge clk);
            #1;
        end
        check_val("flush_no_done", 64'(seen), 64'd0);
        check_val("flush_hold", mult_div_result, prev);
        run_op(F_MULTU, 32'd5, 32'd6, "after_flush");

        // reset mid-CALC
        @(negedge clk);
        funct = F_MULTU; operand_1 = 32'd5; operand_2 = 32'd6; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_outputs", {61'd0, busy, stall_request, mult_div_done}, 64'd0);
        check_val("rst_result", mult_div_result, 64'd0);
        seen = 0;
        repeat (40) begin
            if (mult_div_done) seen++;
            @(posedge clk);
            #1;
        end
        check_val("rst_no_done", 64'(seen), 64'd0);

        // start during CALC is ignored
        exp = ref_result(F_MULT, 32'hFFFF_FF85, 32'd1000);
        @(negedge clk);
        funct = F_MULT; operand_1 = 32'hFFFF_FF85; operand_2 = 32'd1000; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        funct = F_DIVU; operand_1 = 32'd12345; operand_2 = 32'd3; start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("ign_stall", 64'(stall_request), 64'd1);
        start = 1'b0;
        wait_done(8, 60, lat, busy_bad);
        check_val("ign_latency", 64'(lat), 64'd34);
        check_val("ign_result", mult_div_result, exp);
        @(posedge clk);
        #1;

        // unrecognised funct and flush-over-start in IDLE
        @(negedge clk);
        funct = F_MFHI; operand_1 = 32'd9; operand_2 = 32'd9; start = 1'b1;
        #1;
        check_val("mfhi_stall", 64'(stall_request), 64'd0);
        @(posedge clk);
        #1;
        check_val("mfhi_busy", 64'(busy), 64'd0);
        @(negedge clk);
        funct = F_MULTU; flush = 1'b1;
        #1;
        check_val("flush_start_stall", 64'(stall_request), 64'd0);
        @(posedge clk);
        #1;
        check_val("flush_start_busy", 64'(busy), 64'd0);
        start = 1'b0; flush = 1'b0;

        for (int i = 0; i < 24; i++) begin
            f = fsel[$urandom_range(0, 3)];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: a = 32'h8000_0000;
                2: b = 32'hFFFF_FFFF;
                3: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(f, a, b, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
